// File: rtl/microsequencer.sv
// Microprogram sequencer: walks the control address register through the control store,
// dispatching on the IR opcode and stalling on memory-wait microinstructions.
module microsequencer #(
    parameter int sz          = 22,
    parameter int N           = 7,
    parameter int n           = 4,
    parameter int OPW         = 5,
    parameter int MAX_OP      = 16,
    parameter int TIMEOUT     = 64,
    parameter int WMFC_BIT    = 8,
    parameter int RNW_BIT     = 9,
    parameter int SEL_DEC_BIT = 16,
    parameter int END_BIT     = sz - 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [sz-1:0]  CBR,
    input  logic [OPW-1:0] opcode,
    input  logic           mfc,
    output logic [N-1:0]   CAR,
    output logic [sz-1:0]  ctrl_word,
    output logic           busy_wait,
    output logic           illegal_op,
    output logic           mem_timeout,
    output logic           halted,
    output logic [15:0]    instr_count
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    // While stalled only the memory-request bits stay asserted so one-shot strobes fire once.
    localparam logic [sz-1:0] WAIT_MASK = (sz'(1) << WMFC_BIT) | (sz'(1) << RNW_BIT);

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_cnt_nxt;
    logic [N-1:0]   car_nxt;
    logic [15:0]    count_nxt;
    logic           illegal_nxt;
    logic           timeout_nxt;

    logic           op_legal;
    logic [N-1:0]   disp_addr;
    logic [N-1:0]   car_inc;

    assign op_legal  = (opcode != '0) && (32'(opcode) <= 32'(MAX_OP));
    assign disp_addr = N'(opcode) * N'(n);
    assign car_inc   = CAR + N'(1);

    always_comb begin
        state_nxt    = state;
        car_nxt      = CAR;
        wait_cnt_nxt = wait_cnt;
        count_nxt    = instr_count;
        illegal_nxt  = 1'b0;
        timeout_nxt  = mem_timeout;

        case (state)
            ST_RUN, ST_WAIT: begin
                if (CBR[END_BIT]) begin
                    car_nxt      = '0;
                    count_nxt    = instr_count + 16'd1;
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (CBR[SEL_DEC_BIT]) begin
                    if (op_legal) begin
                        car_nxt = disp_addr;
                    end else begin
                        car_nxt     = '0;
                        illegal_nxt = 1'b1;
                    end
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (CBR[WMFC_BIT] && !mfc) begin
                    // The RUN cycle that issues the request is not itself a stalled cycle.
                    if (state == ST_RUN) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = '0;
                    end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                        state_nxt    = ST_HALT;
                        car_nxt      = '0;
                        timeout_nxt  = 1'b1;
                        wait_cnt_nxt = '0;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WCW'(1);
                    end
                end else begin
                    car_nxt      = car_inc;
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end
            end
            ST_HALT: begin
                car_nxt      = '0;
                wait_cnt_nxt = '0;
            end
            default: begin
                state_nxt    = ST_RUN;
                car_nxt      = '0;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            CAR         <= '0;
            wait_cnt    <= '0;
            instr_count <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            CAR         <= car_nxt;
            wait_cnt    <= wait_cnt_nxt;
            instr_count <= count_nxt;
            illegal_op  <= illegal_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

    always_comb begin
        case (state)
            ST_RUN:  ctrl_word = CBR;
            ST_WAIT: ctrl_word = CBR & WAIT_MASK;
            default: ctrl_word = '0;
        endcase
    end

    assign busy_wait = (state == ST_WAIT);
    assign halted    = (state == ST_HALT);

endmodule
